// File: rtl/regfile_mp_pkg.sv
// Shared types for the multi-port accumulator register file: decoded op codes and
// the two-state SWAP sequencer encoding.
package regfile_mp_pkg;

    typedef enum logic [2:0] {
        kRF_NOP   = 3'd0,
        kRF_WRITE = 3'd1,
        kRF_LDI   = 3'd2,
        kRF_MOVIN = 3'd3,
        kRF_MOV   = 3'd4,
        kRF_SWAP  = 3'd5
    } rf_op_t;

    typedef enum logic {
        kRF_IDLE  = 1'b0,
        kRF_SWAP2 = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_mp_wr_ctl.sv
// Write-port controller: turns the presented op and sequencer state into the single
// array write (enable/address/data), the next state, Busy and the SWAP temp load.
module rf_wr_ctl
    import regfile_mp_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 4
) (
    input  rf_state_t      state_q_i,
    input  logic           op_valid_i,
    input  rf_op_t         op_i,
    input  logic [D-1:0]   rd_i,
    input  logic [D-1:0]   swap_rs_q_i,
    input  logic [W-1:0]   imm_i,
    input  logic [W-1:0]   data_in_i,
    input  logic [W-1:0]   acc_i,
    input  logic [W-1:0]   rs_data_i,
    input  logic [W-1:0]   tmp_q_i,
    output logic           wr_en_o,
    output logic [D-1:0]   wr_addr_o,
    output logic [W-1:0]   wr_data_o,
    output rf_state_t      state_d_o,
    output logic           busy_d_o,
    output logic           tmp_we_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        wr_en_o   = 1'b0;
        wr_addr_o = rd_i;
        wr_data_o = data_in_i;
        state_d_o = state_q_i;
        tmp_we_o  = 1'b0;

        case (state_q_i)
            kRF_IDLE: begin
                if (op_valid_i) begin
                    case (op_i)
                        kRF_WRITE: wr_en_o = 1'b1;
                        kRF_LDI: begin
                            wr_en_o   = 1'b1;
                            wr_addr_o = '0;
                            wr_data_o = imm_i;
                        end
                        kRF_MOVIN: begin
                            wr_en_o   = 1'b1;
                            wr_data_o = acc_i;
                        end
                        kRF_MOV: begin
                            wr_en_o   = 1'b1;
                            wr_data_o = rs_data_i;
                        end
                        kRF_SWAP: begin
                            wr_en_o   = 1'b1;
                            wr_data_o = rs_data_i;
                            tmp_we_o  = 1'b1;
                            state_d_o = kRF_SWAP2;
                        end
                        default: ;
                    endcase
                end
            end
            kRF_SWAP2: begin
                // Second half of SWAP; whatever is presented this cycle is dropped.
                wr_en_o   = 1'b1;
                wr_addr_o = swap_rs_q_i;
                wr_data_o = tmp_q_i;
                state_d_o = kRF_IDLE;
            end
            default: state_d_o = kRF_IDLE;
        endcase

        busy_d_o = (state_d_o == kRF_SWAP2);
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with R0 as accumulator: NR combinational read ports,
// one op-driven write port, optional write-through bypass and a two-cycle SWAP.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int W      = 8,
    parameter int D      = 4,
    parameter int NR     = 3,
    parameter int BYPASS = 0
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  OpValid,
    input  rf_op_t                Op,
    input  logic [D-1:0]          Rd,
    input  logic [D-1:0]          Rs,
    input  logic [W-1:0]          Imm,
    input  logic [W-1:0]          DataIn,
    input  logic [NR-1:0][D-1:0]  RdAddr,
    output logic [NR-1:0][W-1:0]  RdData,
    output logic [W-1:0]          Acc,
    output logic                  Busy
);

    localparam int NREGS = 2 ** D;

    logic [W-1:0] regs_q [NREGS];
    rf_state_t    state_q, state_d;
    logic         busy_q, busy_d;
    logic [W-1:0] tmp_q;
    logic [D-1:0] swap_rs_q;

    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         tmp_we;

    rf_wr_ctl #(.W(W), .D(D)) u_wr_ctl (
        .state_q_i   (state_q),
        .op_valid_i  (OpValid),
        .op_i        (Op),
        .rd_i        (Rd),
        .swap_rs_q_i (swap_rs_q),
        .imm_i       (Imm),
        .data_in_i   (DataIn),
        .acc_i       (regs_q[0]),
        .rs_data_i   (regs_q[Rs]),
        .tmp_q_i     (tmp_q),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .state_d_o   (state_d),
        .busy_d_o    (busy_d),
        .tmp_we_o    (tmp_we)
    );

    // NOTE: the array is reset explicitly because a cleared register file (and a zero
    // accumulator) is architectural state, so it is built from flops, not a RAM macro.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or process order.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= kRF_IDLE;
            busy_q    <= 1'b0;
            tmp_q     <= '0;
            swap_rs_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (tmp_we) begin
                tmp_q     <= regs_q[Rd];
                swap_rs_q <= Rs;
            end
        end
    end

    assign Busy = busy_q;

    // With bypass enabled a read hitting the address being committed sees the new value.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            RdData[i] = regs_q[RdAddr[i]];
            if ((BYPASS != 0) && wr_en && (RdAddr[i] == wr_addr)) begin
                RdData[i] = wr_data;
            end
        end
        Acc = regs_q[0];
        if ((BYPASS != 0) && wr_en && (wr_addr == '0)) begin
            Acc = wr_data;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one instance without and one with bypass share the
// same stimulus; expected outputs are queued and a monitor compares them on request.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NR = 3;

  localparam int K_RD   = 0;
  localparam int K_ACC  = 1;
  localparam int K_BUSY = 2;

  typedef struct {
    string        name;
    int           dut;
    int           kind;
    int           port;
    logic [W-1:0] exp;
  } exp_t;

  logic                 Clk;
  logic                 ResetN;
  logic                 OpValid;
  rf_op_t               Op;
  logic [D-1:0]         Rd;
  logic [D-1:0]         Rs;
  logic [W-1:0]         Imm;
  logic [W-1:0]         DataIn;
  logic [NR-1:0][D-1:0] RdAddr;
  logic [NR-1:0][W-1:0] rd_data0, rd_data1;
  logic [W-1:0]         acc0, acc1;
  logic                 busy0, busy1;

  exp_t sb[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_mp #(.W(W), .D(D), .NR(NR), .BYPASS(0)) u_dut0 (
    .Clk(Clk), .ResetN(ResetN), .OpValid(OpValid), .Op(Op), .Rd(Rd), .Rs(Rs),
    .Imm(Imm), .DataIn(DataIn), .RdAddr(RdAddr), .RdData(rd_data0), .Acc(acc0),
    .Busy(busy0)
  );

  regfile_mp #(.W(W), .D(D), .NR(NR), .BYPASS(1)) u_dut1 (
    .Clk(Clk), .ResetN(ResetN), .OpValid(OpValid), .Op(Op), .Rd(Rd), .Rs(Rs),
    .Imm(Imm), .DataIn(DataIn), .RdAddr(RdAddr), .RdData(rd_data1), .Acc(acc1),
    .Busy(busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: drains the scoreboard each time the stimulus requests a sample.
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        exp_t         e;
        logic [W-1:0] act;
        e = sb.pop_front();
        case (e.kind)
          K_RD:    act = (e.dut == 0) ? rd_data0[e.port] : rd_data1[e.port];
          K_ACC:   act = (e.dut == 0) ? acc0 : acc1;
          default: act = {{(W-1){1'b0}}, ((e.dut == 0) ? busy0 : busy1)};
        endcase
        check($sformatf("%s (dut%0d)", e.name, e.dut), act, e.exp);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "bench timed out");
  end

  task automatic push(input string name, input int dut, input int kind, input int port,
                      input logic [W-1:0] exp);
    exp_t e;
    e.name = name; e.dut = dut; e.kind = kind; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push2(input string name, input int kind, input int port,
                       input logic [W-1:0] exp);
    push(name, 0, kind, port, exp);
    push(name, 1, kind, port, exp);
  endtask

  task automatic sample();
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic drive(input rf_op_t op, input logic [D-1:0] rd, input logic [D-1:0] rs,
                       input logic [W-1:0] imm, input logic [W-1:0] din);
    OpValid = 1'b1; Op = op; Rd = rd; Rs = rs; Imm = imm; DataIn = din;
  endtask

  task automatic idle();
    OpValid = 1'b0; Op = kRF_NOP;
  endtask

  initial begin
    ResetN = 1'b0;
    idle();
    Rd = '0; Rs = '0; Imm = '0; DataIn = '0;
    RdAddr = '0;

    // Power-on reset state
    sample();
    push2("por_acc", K_ACC, 0, 8'h00);
    push2("por_busy", K_BUSY, 0, 8'h00);
    sample();
    ResetN = 1'b1;

    // 1: load R5, then async reset mid-cycle clears it at once
    tick();
    drive(kRF_WRITE, 4'd5, 4'd0, 8'h00, 8'h3C);
    tick();
    idle();
    RdAddr[0] = 4'd5;
    push2("r5_loaded", K_RD, 0, 8'h3C);
    sample();
    ResetN = 1'b0;
    push2("rst_r5", K_RD, 0, 8'h00);
    push2("rst_acc", K_ACC, 0, 8'h00);
    push2("rst_busy", K_BUSY, 0, 8'h00);
    sample();
    ResetN = 1'b1;

    // 2: LDI then MOVIN; Acc bypass only in the BYPASS=1 instance
    tick();
    drive(kRF_LDI, 4'd3, 4'd0, 8'hA5, 8'h00);
    RdAddr[0] = 4'd3;
    push("ldi_acc_pre", 0, K_ACC, 0, 8'h00);
    push("ldi_acc_pre", 1, K_ACC, 0, 8'hA5);
    push2("ldi_rd_ignored", K_RD, 0, 8'h00);
    sample();
    tick();
    drive(kRF_MOVIN, 4'd7, 4'd0, 8'h00, 8'h00);
    RdAddr[0] = 4'd7;
    push2("ldi_acc", K_ACC, 0, 8'hA5);
    push("movin_r7_pre", 0, K_RD, 0, 8'h00);
    push("movin_r7_pre", 1, K_RD, 0, 8'hA5);
    sample();
    tick();
    idle();
    push2("movin_r7", K_RD, 0, 8'hA5);
    sample();

    // MOV, MOV onto itself, and WRITE to R0 updating the accumulator
    drive(kRF_MOV, 4'd10, 4'd7, 8'h00, 8'h00);
    tick();
    drive(kRF_MOV, 4'd7, 4'd7, 8'h00, 8'h00);
    tick();
    drive(kRF_WRITE, 4'd0, 4'd0, 8'h00, 8'h3E);
    tick();
    idle();
    RdAddr[0] = 4'd10;
    RdAddr[1] = 4'd7;
    push2("mov_r10", K_RD, 0, 8'hA5);
    push2("mov_self_r7", K_RD, 1, 8'hA5);
    push2("write_r0_acc", K_ACC, 0, 8'h3E);
    sample();

    // 3: SWAP R2/R9 with a WRITE dropped during Busy
    drive(kRF_WRITE, 4'd2, 4'd0, 8'h00, 8'h11);
    tick();
    drive(kRF_WRITE, 4'd9, 4'd0, 8'h00, 8'h22);
    tick();
    drive(kRF_SWAP, 4'd2, 4'd9, 8'h00, 8'h00);
    RdAddr[0] = 4'd2;
    RdAddr[1] = 4'd9;
    push("swap_r2_pre", 0, K_RD, 0, 8'h11);
    push("swap_r2_pre", 1, K_RD, 0, 8'h22);
    push2("swap_busy_pre", K_BUSY, 0, 8'h00);
    sample();
    tick();
    drive(kRF_WRITE, 4'd2, 4'd0, 8'h00, 8'hEE);
    push2("swap2_busy", K_BUSY, 0, 8'h01);
    push2("swap2_r2", K_RD, 0, 8'h22);
    push("swap2_r9", 0, K_RD, 1, 8'h22);
    push("swap2_r9", 1, K_RD, 1, 8'h11);
    sample();
    tick();
    idle();
    push2("swap_done_busy", K_BUSY, 0, 8'h00);
    push2("swap_done_r9", K_RD, 1, 8'h11);
    push2("swap_dropped_write_r2", K_RD, 0, 8'h22);
    sample();

    // 4: WRITE R4 read on all ports in the same cycle
    drive(kRF_WRITE, 4'd4, 4'd0, 8'h00, 8'h5A);
    RdAddr = {4'd4, 4'd4, 4'd4};
    for (int i = 0; i < NR; i++) begin
      push("byp_port_pre", 0, K_RD, i, 8'h00);
      push("byp_port_pre", 1, K_RD, i, 8'h5A);
    end
    sample();
    tick();
    idle();
    for (int i = 0; i < NR; i++) begin
      push2("byp_port_post", K_RD, i, 8'h5A);
    end
    sample();

    // 5: SWAP R3 with itself, then reset during SWAP2
    drive(kRF_WRITE, 4'd3, 4'd0, 8'h00, 8'h77);
    tick();
    drive(kRF_SWAP, 4'd3, 4'd3, 8'h00, 8'h00);
    tick();
    idle();
    RdAddr[0] = 4'd3;
    push2("swap_self_busy", K_BUSY, 0, 8'h01);
    push2("swap_self_r3_mid", K_RD, 0, 8'h77);
    sample();
    tick();
    push2("swap_self_busy_done", K_BUSY, 0, 8'h00);
    push2("swap_self_r3", K_RD, 0, 8'h77);
    sample();
    drive(kRF_SWAP, 4'd3, 4'd3, 8'h00, 8'h00);
    tick();
    idle();
    push2("swap_rst_busy_pre", K_BUSY, 0, 8'h01);
    sample();
    ResetN = 1'b0;
    push2("swap_rst_busy", K_BUSY, 0, 8'h00);
    push2("swap_rst_r3", K_RD, 0, 8'h00);
    sample();
    ResetN = 1'b1;
    tick();
    push2("swap_abort_busy", K_BUSY, 0, 8'h00);
    push2("swap_abort_r3", K_RD, 0, 8'h00);
    sample();

    check("end_busy_dut0", {{(W-1){1'b0}}, busy0}, 8'h00);
    check("end_busy_dut1", {{(W-1){1'b0}}, busy1}, 8'h00);
    check("end_acc_dut0", acc0, 8'h00);
    check("end_acc_dut1", acc1, 8'h00);

    #2;
    if ((n_pass == n_checks) && (n_checks >= 12)) begin
      $display("PASS: %0d/%0d checks passed", n_pass, n_checks);
    end else begin
      $display("FAIL: %0d/%0d checks passed", n_pass, n_checks);
    end
    $finish;
  end

endmodule
